ram_dp_param: RTL and testbench

- Parametrised dual-port (1W/1R) synchronous RAM that generalises the fixed 64x4K RAM: configurable width, depth and byte-lane write enables.
- Adds hardware clear-on-reset via an internal sweep FSM, a write-first read-during-write bypass, and out-of-range address detection.
- Sits under the SoC memory subsystem as the storage primitive for the dual-port RAM banks.

---
 rtl/ram_dp_param.sv | 167 ++++++++++++++++
 tb/tb_ram_dp_param.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised 1W/1R synchronous RAM with byte-lane write enables,
// a power-up/clear zeroing sweep, write-first read-during-write bypass and
// out-of-range address detection.
// Optional feature macro: RAM_PARITY_EN adds per-lane even parity storage and
// a par_err output that qualifies each valid read.
module ram_dp_param #(
    parameter  int unsigned RAM_WIDTH = 64,
    parameter  int unsigned ADDR_SIZE = 12,
    parameter  int unsigned DEPTH     = 4096,
    localparam int unsigned NBYTES    = RAM_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 write,
    input  logic [ADDR_SIZE-1:0] wr_address,
    input  logic [NBYTES-1:0]    wr_be,
    input  logic [RAM_WIDTH-1:0] data_in,
    input  logic                 read,
    input  logic [ADDR_SIZE-1:0] rd_address,
    output logic [RAM_WIDTH-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
`ifdef RAM_PARITY_EN
    output logic                 addr_err,
    output logic                 par_err
`else
    output logic                 addr_err
`endif
);

    // Counter is one bit wider than the address so DEPTH == 2**ADDR_SIZE is reachable.
    localparam int unsigned     CNT_W   = ADDR_SIZE + 1;
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic                 ready_c;
    logic                 rd_range_c;
    logic                 wr_range_c;
    logic                 rd_ok_c;
    logic                 wr_ok_c;
    logic                 bad_req_c;
    logic                 same_c;
    logic [RAM_WIDTH-1:0] rd_word_c;

    // Request qualification: only READY services requests, and only in-range ones.
    assign ready_c    = (state == ST_READY);
    assign rd_range_c = ({1'b0, rd_address} < DEPTH_C);
    assign wr_range_c = ({1'b0, wr_address} < DEPTH_C);
    assign rd_ok_c    = ready_c && read && rd_range_c;
    assign wr_ok_c    = ready_c && write && wr_range_c;
    assign bad_req_c  = ready_c && ((read && !rd_range_c) || (write && !wr_range_c));
    assign same_c     = rd_ok_c && wr_ok_c && (rd_address == wr_address);

    // Read word with write-first bypass of the enabled lanes on an address collision.
    always_comb begin
        rd_word_c = mem[IDX_W'(rd_address)];
        if (same_c) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (wr_be[i]) begin
                    rd_word_c[8*i +: 8] = data_in[8*i +: 8];
                end
            end
        end
    end

    // Storage array: the sweep zeroes one word per cycle, otherwise lane-masked writes.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[IDX_W'(cnt)] <= '0;
        end else if (wr_ok_c) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (wr_be[i]) begin
                    mem[IDX_W'(wr_address)][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [NBYTES-1:0] par_mem [DEPTH];
    logic [NBYTES-1:0] wr_par_c;
    logic [NBYTES-1:0] rd_par_c;
    logic [NBYTES-1:0] rd_calc_c;
    logic              par_bad_c;

    // Parity of incoming data, stored parity (bypassed lanes take the new parity)
    // and parity recomputed over the word actually returned.
    always_comb begin
        wr_par_c  = '0;
        rd_calc_c = '0;
        rd_par_c  = par_mem[IDX_W'(rd_address)];
        for (int i = 0; i < int'(NBYTES); i++) begin
            wr_par_c[i]  = ^data_in[8*i +: 8];
            rd_calc_c[i] = ^rd_word_c[8*i +: 8];
            if (same_c && wr_be[i]) begin
                rd_par_c[i] = wr_par_c[i];
            end
        end
        par_bad_c = |(rd_par_c ^ rd_calc_c);
    end

    // Parity array follows the data array lane for lane; the sweep stores 0.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            par_mem[IDX_W'(cnt)] <= '0;
        end else if (wr_ok_c) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (wr_be[i]) begin
                    par_mem[IDX_W'(wr_address)][i] <= wr_par_c[i];
                end
            end
        end
    end

    // Parity error flag, pulsed alongside data_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_ok_c && par_bad_c;
        end
    end
`endif

    // Sweep FSM and registered read/status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_INIT;
            cnt        <= '0;
            busy       <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            data_valid <= rd_ok_c;
            addr_err   <= bad_req_c;
            if (rd_ok_c) begin
                data_out <= rd_word_c;
            end
            if (state == ST_INIT) begin
                if (cnt == LAST_C) begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (clear) begin
                state <= ST_INIT;
                busy  <= 1'b1;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: a full-size instance (DEPTH 4096) and a short one
// (DEPTH 3000) share one stimulus stream; a word-array model per instance
// predicts every output each cycle, plus literal checks of the key scenarios.
module tb_ram_dp_param;

    localparam int unsigned DA = 4096;
    localparam int unsigned DB = 3000;
    localparam int unsigned FLIP_ADDR = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear = 1'b0;
    logic        write = 1'b0;
    logic [11:0] wr_address = '0;
    logic [7:0]  wr_be = '0;
    logic [63:0] data_in = '0;
    logic        read = 1'b0;
    logic [11:0] rd_address = '0;

    logic [63:0] dout_a, dout_b;
    logic        dv_a, dv_b, busy_a, busy_b, err_a, err_b;
`ifdef RAM_PARITY_EN
    logic        par_a, par_b;
`endif

    always #5 clk = ~clk;

    ram_dp_param #(.RAM_WIDTH(64), .ADDR_SIZE(12), .DEPTH(DA)) dut_a (
        .clk(clk), .resetn(resetn), .clear(clear), .write(write),
        .wr_address(wr_address), .wr_be(wr_be), .data_in(data_in),
        .read(read), .rd_address(rd_address), .data_out(dout_a),
        .data_valid(dv_a), .busy(busy_a),
`ifdef RAM_PARITY_EN
        .addr_err(err_a), .par_err(par_a)
`else
        .addr_err(err_a)
`endif
    );

    ram_dp_param #(.RAM_WIDTH(64), .ADDR_SIZE(12), .DEPTH(DB)) dut_b (
        .clk(clk), .resetn(resetn), .clear(clear), .write(write),
        .wr_address(wr_address), .wr_be(wr_be), .data_in(data_in),
        .read(read), .rd_address(rd_address), .data_out(dout_b),
        .data_valid(dv_b), .busy(busy_b),
`ifdef RAM_PARITY_EN
        .addr_err(err_b), .par_err(par_b)
`else
        .addr_err(err_b)
`endif
    );

    // ---------------- behavioural model ----------------
    logic [63:0] mm [2][4096];
    logic [7:0]  mc [2][4096];
    int          busy_left [2];
    logic [63:0] e_dout [2];
    logic        e_dv [2];
    logic        e_err [2];
    logic        e_busy [2];
    logic        e_par [2];
    int          flip_req = 0;
    int          flip_done = 0;

    function automatic int depth_of(input int k);
        return (k == 0) ? int'(DA) : int'(DB);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic zero_model(input int k);
        for (int a = 0; a < 4096; a++) begin
            mm[k][a] = '0;
            mc[k][a] = '0;
        end
    endtask

    task automatic model_step(input int k);
        int d;
        logic rd_ok, wr_ok;
        logic [63:0] nw;
        d = depth_of(k);
        e_dv[k]  = 1'b0;
        e_err[k] = 1'b0;
        e_par[k] = 1'b0;
        if (busy_left[k] > 0) begin
            busy_left[k] = busy_left[k] - 1;
            e_busy[k] = (busy_left[k] != 0);
        end else begin
            rd_ok = read && (int'(rd_address) < d);
            wr_ok = write && (int'(wr_address) < d);
            e_err[k] = (read && !rd_ok) || (write && !wr_ok);
            nw = merge(mm[k][wr_address], data_in, wr_be);
            if (rd_ok) begin
                e_dv[k] = 1'b1;
                if (wr_ok && wr_address == rd_address) begin
                    e_dout[k] = nw;
                    e_par[k]  = |(mc[k][rd_address] & ~wr_be);
                end else begin
                    e_dout[k] = mm[k][rd_address];
                    e_par[k]  = |mc[k][rd_address];
                end
            end
            if (wr_ok) begin
                mm[k][wr_address] = nw;
                mc[k][wr_address] = mc[k][wr_address] & ~wr_be;
            end
            if (clear) begin
                zero_model(k);
                busy_left[k] = d;
                e_busy[k] = 1'b1;
            end
        end
    endtask

    // Model advances on every clock edge and resets with the DUT.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                zero_model(k);
                busy_left[k] = depth_of(k);
                e_dout[k] = '0;
                e_dv[k]   = 1'b0;
                e_err[k]  = 1'b0;
                e_busy[k] = 1'b1;
                e_par[k]  = 1'b0;
            end
        end else begin
            if (flip_req != flip_done) begin
                for (int k = 0; k < 2; k++) begin
                    mm[k][FLIP_ADDR][0] = ~mm[k][FLIP_ADDR][0];
                    mc[k][FLIP_ADDR][0] = ~mc[k][FLIP_ADDR][0];
                end
                flip_done = flip_req;
            end
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (chk_on) begin
            chk("a.data_valid", 64'(dv_a), 64'(e_dv[0]));
            chk("a.busy", 64'(busy_a), 64'(e_busy[0]));
            chk("a.addr_err", 64'(err_a), 64'(e_err[0]));
            chk("a.data_out", dout_a, e_dout[0]);
            chk("b.data_valid", 64'(dv_b), 64'(e_dv[1]));
            chk("b.busy", 64'(busy_b), 64'(e_busy[1]));
            chk("b.addr_err", 64'(err_b), 64'(e_err[1]));
            chk("b.data_out", dout_b, e_dout[1]);
`ifdef RAM_PARITY_EN
            chk("a.par_err", 64'(par_a), 64'(e_par[0]));
            chk("b.par_err", 64'(par_b), 64'(e_par[1]));
`endif
        end
    endtask

    // Outputs are sampled on the falling edge, half a period after the update.
    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cyc(input logic rd, input logic [11:0] ra, input logic wr,
                       input logic [11:0] wa, input logic [7:0] be,
                       input logic [63:0] din, input logic clr);
        read = rd; rd_address = ra; write = wr; wr_address = wa;
        wr_be = be; data_in = din; clear = clr;
        tick();
    endtask

    task automatic idle();
        cyc(1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
    endtask

    // Counts falling edges until busy_a drops; bounded so a stuck sweep still ends.
    task automatic sweep_measure(output int n, output int nb, output int dvs);
        n = 0; nb = 0; dvs = 0;
        while (busy_a && n < 6000) begin
            tick();
            n++;
            if (!busy_b && nb == 0) nb = n;
            if (dv_a && busy_a) dvs++;
        end
    endtask

    typedef struct {
        logic        rd;
        logic [11:0] ra;
        logic        wr;
        logic [11:0] wa;
        logic [7:0]  be;
        logic [63:0] din;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n, nb, dvs;
        resetn = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        tick();
        chk("reset.busy", 64'(busy_a), 64'd1);
        chk("reset.data_valid", 64'(dv_a), 64'd0);
        chk("reset.data_out", dout_a, 64'h0);

        // Release reset with a read of address 0 held throughout the sweep.
        read = 1'b1; rd_address = 12'h000;
        resetn = 1'b1;
        sweep_measure(n, nb, dvs);
        chk("sweep.len_4096", 64'(n), 64'd4096);
        chk("sweep.len_3000", 64'(nb), 64'd3000);
        chk("sweep.no_valid", 64'(dvs), 64'd0);
        tick();
        chk("post_sweep.valid", 64'(dv_a), 64'd1);
        chk("post_sweep.data", dout_a, 64'h0);

        // Full-word write then read back.
        cyc(1'b0, 12'h000, 1'b1, 12'h005, 8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b0);
        chk("write_only.no_valid", 64'(dv_a), 64'd0);
        cyc(1'b1, 12'h005, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("rd5.valid", 64'(dv_a), 64'd1);
        chk("rd5.data", dout_a, 64'h1234_5678_9ABC_DEF0);

        // Partial-lane write colliding with a read of the same address.
        cyc(1'b1, 12'h005, 1'b1, 12'h005, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("bypass.valid", 64'(dv_a), 64'd1);
        chk("bypass.data", dout_a, 64'h1234_5678_FFFF_FFFF);
        cyc(1'b1, 12'h005, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("bypass.persist", dout_a, 64'h1234_5678_FFFF_FFFF);

        // Out-of-range write and read together on the 3000-deep instance.
        cyc(1'b1, 12'hFFF, 1'b1, 12'hBB8, 8'hFF, 64'hDEAD_BEEF_0000_1111, 1'b0);
        chk("oob.err_b", 64'(err_b), 64'd1);
        chk("oob.no_valid_b", 64'(dv_b), 64'd0);
        chk("oob.no_err_a", 64'(err_a), 64'd0);
        cyc(1'b1, 12'h000, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("oob.single_pulse", 64'(err_b), 64'd0);
        chk("oob.addr0_b", dout_b, 64'h0);
        cyc(1'b1, 12'hBB8, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("oob.a_wrote", dout_a, 64'hDEAD_BEEF_0000_1111);

        // Clear with a request in the clear cycle, then reset mid-sweep.
        cyc(1'b0, 12'h000, 1'b1, 12'h010, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        cyc(1'b1, 12'h010, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("pre_clear.data", dout_a, 64'hA5A5_A5A5_A5A5_A5A5);
        cyc(1'b1, 12'h010, 1'b0, 12'h000, 8'h00, 64'h0, 1'b1);
        chk("clear_cycle.valid", 64'(dv_a), 64'd1);
        chk("clear_cycle.busy", 64'(busy_a), 64'd1);
        repeat (10) idle();
        resetn = 1'b0;
        tick();
        chk("midreset.busy", 64'(busy_a), 64'd1);
        chk("midreset.valid", 64'(dv_a), 64'd0);
        resetn = 1'b1;
        sweep_measure(n, nb, dvs);
        chk("resweep.len_4096", 64'(n), 64'd4096);
        chk("resweep.len_3000", 64'(nb), 64'd3000);
        cyc(1'b1, 12'h010, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("cleared.data", dout_a, 64'h0);
        chk("cleared.valid", 64'(dv_a), 64'd1);

        // wr_be of zero changes nothing.
        cyc(1'b0, 12'h000, 1'b1, 12'h005, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        cyc(1'b1, 12'h005, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("be0.noop", dout_a, 64'h0);

        // Directed mix: back-to-back reads, lane patterns, edge addresses.
        vecs[0] = '{1'b0, 12'h000, 1'b1, 12'h7FF, 8'hA5, 64'h0102_0304_0506_0708};
        vecs[1] = '{1'b1, 12'h7FF, 1'b1, 12'hBB7, 8'hFF, 64'hCAFE_F00D_1234_5678};
        vecs[2] = '{1'b1, 12'hBB7, 1'b0, 12'h000, 8'h00, 64'h0};
        vecs[3] = '{1'b1, 12'hBB8, 1'b1, 12'hFFF, 8'h3C, 64'h1111_2222_3333_4444};
        vecs[4] = '{1'b1, 12'hFFF, 1'b1, 12'h7FF, 8'h5A, 64'hFFFF_0000_FFFF_0000};
        vecs[5] = '{1'b1, 12'h7FF, 1'b1, 12'h7FF, 8'hF0, 64'h8888_7777_6666_5555};
        vecs[6] = '{1'b1, 12'h7FF, 1'b0, 12'h000, 8'h00, 64'h0};
        vecs[7] = '{1'b0, 12'h000, 1'b1, 12'h000, 8'h81, 64'hAB00_0000_0000_00CD};
        vecs[8] = '{1'b1, 12'h000, 1'b0, 12'h000, 8'h00, 64'h0};
        vecs[9] = '{1'b1, 12'hC00, 1'b0, 12'h000, 8'h00, 64'h0};
        foreach (vecs[i]) cyc(vecs[i].rd, vecs[i].ra, vecs[i].wr, vecs[i].wa, vecs[i].be, vecs[i].din, 1'b0);
        idle();
        cyc(1'b1, 12'h000, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("vec.addr0", dout_a, 64'hAB00_0000_0000_00CD);
        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                8'($urandom), {32'($urandom), 32'($urandom)}, 1'b0);
        end
        idle();

`ifdef RAM_PARITY_EN
        // Corrupt one stored bit behind the parity and read it back.
        cyc(1'b0, 12'h000, 1'b1, 12'(FLIP_ADDR), 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        cyc(1'b1, 12'(FLIP_ADDR), 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("par.clean", 64'(par_a), 64'd0);
        dut_a.mem[FLIP_ADDR] = dut_a.mem[FLIP_ADDR] ^ 64'h1;
        dut_b.mem[FLIP_ADDR] = dut_b.mem[FLIP_ADDR] ^ 64'h1;
        flip_req = flip_req + 1;
        idle();
        cyc(1'b1, 12'(FLIP_ADDR), 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("par.flip_err", 64'(par_a), 64'd1);
        chk("par.flip_valid", 64'(dv_a), 64'd1);
        chk("par.flip_data", dout_a, 64'h0123_4567_89AB_CDEE);
        cyc(1'b1, 12'h005, 1'b0, 12'h000, 8'h00, 64'h0, 1'b0);
        chk("par.other_clean", 64'(par_a), 64'd0);
        cyc(1'b1, 12'(FLIP_ADDR), 1'b1, 12'(FLIP_ADDR), 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        chk("par.bypass_clean", 64'(par_a), 64'd0);
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case something never returns.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
